// File: rtl/fetch_seq_ctrl_if.sv
// Instruction-memory request/response bus: req/ready issue handshake, rvalid return.
interface fetch_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             imem_req_o;
    logic [WIDTH-1:0] imem_addr_o;
    logic             imem_ready_i;
    logic             imem_rvalid_i;
    logic [WIDTH-1:0] imem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_ready_i, imem_rvalid_i, imem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_ready_i, imem_rvalid_i, imem_rdata_i
    );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: one outstanding imem request, registered instr/pc to decode, squashes wrong-path data.
// Output loads the cycle after rvalid; decode stall withholds new requests while the output register is occupied.
module fetch_seq_ctrl #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] target_i,
    fetch_seq_ctrl_if.master imem,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             instr_valid_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    state_t           state;
    state_t           state_nxt;
    logic             req;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] target_word;
    logic             load;
    logic             consume;

    assign target_word      = {target_i[WIDTH-1:2], 2'b00};
    assign load             = (state == S_WAIT) && imem.imem_rvalid_i;
    assign consume          = instr_valid_o && !stall_i;
    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = fetch_pc;
    assign pc_plus4_o       = pc_o + FOUR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Issuing only when the output register is empty or draining guarantees
    // a free slot by the time the response lands.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            S_REQ: begin
                req = rst && (!instr_valid_o || !stall_i);
                if (req && imem.imem_ready_i) begin
                    state_nxt = redirect_i ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid_i) begin
                    state_nxt = S_REQ;
                end else if (redirect_i) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem.imem_rvalid_i) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // Redirect wins over both a landing response and a stalled valid instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc      <= RESET_PC;
            instr_o       <= NOP_INSTR;
            pc_o          <= RESET_PC;
            instr_valid_o <= 1'b0;
        end else if (redirect_i) begin
            fetch_pc      <= target_word;
            instr_o       <= NOP_INSTR;
            instr_valid_o <= 1'b0;
        end else if (load) begin
            instr_o       <= imem.imem_rdata_i;
            pc_o          <= fetch_pc;
            instr_valid_o <= 1'b1;
            fetch_pc      <= fetch_pc + FOUR;
        end else if (consume) begin
            instr_o       <= NOP_INSTR;
            instr_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: streaming, stall, redirects, imem backpressure, reset and PC wrap.
module tb_fetch_seq_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall, redirect;
    logic [W-1:0] target;
    logic [W-1:0] instr, pc, pc4;
    logic         valid;

    logic         stall2, redirect2;
    logic [W-1:0] target2;
    logic [W-1:0] instr2, pc2, pc42;
    logic         valid2;

    int checks = 0;
    int errors = 0;

    // memory responder controls
    logic         rdy_en, ovr_en, spur;
    int           rsp_lat;
    logic [W-1:0] ovr_dat, spur_dat;
    logic         rsp_busy;
    int           rsp_cnt;
    logic [W-1:0] rsp_addr;

    fetch_seq_ctrl_if #(.WIDTH(W)) bus ();
    fetch_seq_ctrl_if #(.WIDTH(W)) bus2 ();

    fetch_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect), .target_i(target),
        .imem(bus.master), .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc4), .instr_valid_o(valid)
    );

    fetch_seq_ctrl #(.WIDTH(W), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .stall_i(stall2), .redirect_i(redirect2), .target_i(target2),
        .imem(bus2.master), .instr_o(instr2), .pc_o(pc2), .pc_plus4_o(pc42), .instr_valid_o(valid2)
    );

    always #5 clk = ~clk;

    // Responder for the main DUT: drives at posedge+2, samples handshake at posedge+6.
    initial begin
        rsp_busy = 1'b0; rsp_cnt = 0; rsp_addr = '0;
        bus.imem_ready_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        forever begin
            @(posedge clk); #2;
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
            if (rsp_busy && rsp_cnt == 1) begin
                rsp_busy = 1'b0;
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = ovr_en ? ovr_dat : {16'hC0DE, rsp_addr[15:0]};
            end else begin
                if (rsp_busy) rsp_cnt--;
                if (spur) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i  = spur_dat;
                end
            end
            bus.imem_ready_i = rdy_en;
            #4;
            if (!rst) rsp_busy = 1'b0;
            else if (bus.imem_req_o && bus.imem_ready_i) begin
                rsp_busy = 1'b1; rsp_cnt = rsp_lat; rsp_addr = bus.imem_addr_o;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        tick; tick; #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req act=%b exp=0", bus.imem_req_o); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid act=%b exp=0", valid); end
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr act=%h exp=00000013", instr); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc act=%h exp=00000000", pc); end
        checks++; if (pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 act=%h exp=00000004", pc4); end
        checks++; if (bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr act=%h exp=00000000", bus.imem_addr_o); end
        checks++; if (pc2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_pc2 act=%h exp=fffffff8", pc2); end
        tick;
        rst = 1'b1;
    endtask

    task automatic test_stream;
        logic [W-1:0] e;
        #2;
        for (int i = 0; i < 2; i++) begin
            e = 32'(4 * i);
            checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== e) begin errors++; $display("FAIL stream_issue req=%b addr=%h exp req=1 addr=%h", bus.imem_req_o, bus.imem_addr_o, e); end
            tick; #2;
            checks++; if (bus.imem_req_o !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL stream_wait req=%b valid=%b exp 0/0", bus.imem_req_o, valid); end
            tick; #2;
            checks++; if (valid !== 1'b1 || pc !== e || pc4 !== e + 32'd4) begin errors++; $display("FAIL stream_out valid=%b pc=%h pc4=%h exp 1 %h %h", valid, pc, pc4, e, e + 32'd4); end
            checks++; if (instr !== {16'hC0DE, e[15:0]}) begin errors++; $display("FAIL stream_instr act=%h exp=%h", instr, {16'hC0DE, e[15:0]}); end
        end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin tick; #3; end
            checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req cyc=%0d act=%b exp=0", k, bus.imem_req_o); end
            checks++; if (valid !== 1'b1 || pc !== 32'h4 || instr !== 32'hC0DE_0004) begin errors++; $display("FAIL stall_hold cyc=%0d valid=%b pc=%h instr=%h exp 1 00000004 c0de0004", k, valid, pc, instr); end
        end
        tick;
        stall = 1'b0; rsp_lat = 3; ovr_en = 1'b1; ovr_dat = 32'hDEAD_BEEF;
        #2;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8) begin errors++; $display("FAIL stall_release req=%b addr=%h exp 1 00000008", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_redirect_wait;
        tick; redirect = 1'b1; target = 32'h100; #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rdw_req_w1 act=%b exp=0", bus.imem_req_o); end
        tick; redirect = 1'b0; #2;
        checks++; if (bus.imem_req_o !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rdw_drop req=%b valid=%b exp 0/0", bus.imem_req_o, valid); end
        tick; #2;
        checks++; if (bus.imem_req_o !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rdw_resp req=%b valid=%b exp 0/0", bus.imem_req_o, valid); end
        tick; ovr_en = 1'b0; rsp_lat = 1; #2;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin errors++; $display("FAIL rdw_newreq req=%b addr=%h exp 1 00000100", bus.imem_req_o, bus.imem_addr_o); end
        checks++; if (valid !== 1'b0 || instr !== 32'h0000_0013) begin errors++; $display("FAIL rdw_squash valid=%b instr=%h exp 0 00000013", valid, instr); end
        tick; #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rdw_wait act=%b exp=0", bus.imem_req_o); end
        tick; #2;
        checks++; if (valid !== 1'b1 || pc !== 32'h100 || instr !== 32'hC0DE_0100) begin errors++; $display("FAIL rdw_out valid=%b pc=%h instr=%h exp 1 00000100 c0de0100", valid, pc, instr); end
    endtask

    task automatic test_redirect_accept;
        redirect = 1'b1; target = 32'h10; #1;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h104) begin errors++; $display("FAIL rda_old req=%b addr=%h exp 1 00000104", bus.imem_req_o, bus.imem_addr_o); end
        tick; redirect = 1'b0; #2;
        checks++; if (bus.imem_req_o !== 1'b0 || valid !== 1'b0 || instr !== 32'h0000_0013) begin errors++; $display("FAIL rda_flush req=%b valid=%b instr=%h exp 0 0 00000013", bus.imem_req_o, valid, instr); end
        tick; redirect = 1'b1; target = 32'h202; #2;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin errors++; $display("FAIL rda_req10 req=%b addr=%h exp 1 00000010", bus.imem_req_o, bus.imem_addr_o); end
        tick; redirect = 1'b0; #2;
        checks++; if (bus.imem_req_o !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rda_drop req=%b valid=%b exp 0/0", bus.imem_req_o, valid); end
        tick; #2;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin errors++; $display("FAIL rda_req200 req=%b addr=%h exp 1 00000200", bus.imem_req_o, bus.imem_addr_o); end
        checks++; if (valid !== 1'b0 || instr !== 32'h0000_0013) begin errors++; $display("FAIL rda_squash valid=%b instr=%h exp 0 00000013", valid, instr); end
        tick; #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rda_wait act=%b exp=0", bus.imem_req_o); end
        tick; #2;
        checks++; if (valid !== 1'b1 || pc !== 32'h200 || instr !== 32'hC0DE_0200) begin errors++; $display("FAIL rda_out valid=%b pc=%h instr=%h exp 1 00000200 c0de0200", valid, pc, instr); end
    endtask

    task automatic test_ready_low;
        rdy_en = 1'b0;
        tick; #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rdy_wait act=%b exp=0", bus.imem_req_o); end
        for (int k = 0; k < 3; k++) begin
            tick;
            if (k == 2) begin redirect = 1'b1; target = 32'h40; end
            #2;
            checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h208) begin errors++; $display("FAIL rdy_hold cyc=%0d req=%b addr=%h exp 1 00000208", k, bus.imem_req_o, bus.imem_addr_o); end
        end
        tick; redirect = 1'b0; rdy_en = 1'b1; #2;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h40) begin errors++; $display("FAIL rdy_redir req=%b addr=%h exp 1 00000040", bus.imem_req_o, bus.imem_addr_o); end
        tick; #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rdy_wait2 act=%b exp=0", bus.imem_req_o); end
        tick; #2;
        checks++; if (valid !== 1'b1 || pc !== 32'h40 || pc4 !== 32'h44 || instr !== 32'hC0DE_0040) begin errors++; $display("FAIL rdy_out valid=%b pc=%h pc4=%h instr=%h exp 1 00000040 00000044 c0de0040", valid, pc, pc4, instr); end
        rsp_lat = 3;
    endtask

    task automatic test_reset_mid_wait;
        tick; #2;
        checks++; if (bus.imem_req_o !== 1'b0 || pc !== 32'h40) begin errors++; $display("FAIL rmw_pre req=%b pc=%h exp 0 00000040", bus.imem_req_o, pc); end
        #1; rst = 1'b0; rdy_en = 1'b0; #1;
        checks++; if (bus.imem_req_o !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rmw_async req=%b valid=%b exp 0/0", bus.imem_req_o, valid); end
        checks++; if (instr !== 32'h0000_0013 || pc !== 32'h0 || pc4 !== 32'h4 || bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL rmw_regs instr=%h pc=%h pc4=%h addr=%h exp 00000013 0 4 0", instr, pc, pc4, bus.imem_addr_o); end
        tick; rst = 1'b1; spur = 1'b1; spur_dat = 32'hBADB_AD00; #2;
        checks++; if (valid !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL rmw_spur valid=%b req=%b addr=%h exp 0 1 0", valid, bus.imem_req_o, bus.imem_addr_o); end
        tick; spur = 1'b0; rdy_en = 1'b1; rsp_lat = 1; #2;
        checks++; if (valid !== 1'b0 || instr !== 32'h0000_0013 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL rmw_ignored valid=%b instr=%h req=%b addr=%h exp 0 00000013 1 0", valid, instr, bus.imem_req_o, bus.imem_addr_o); end
        tick; #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rmw_wait act=%b exp=0", bus.imem_req_o); end
        tick; #2;
        checks++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'hC0DE_0000) begin errors++; $display("FAIL rmw_out valid=%b pc=%h instr=%h exp 1 0 c0de0000", valid, pc, instr); end
    endtask

    task automatic test_wrap;
        tick; bus2.imem_ready_i = 1'b1; #2;
        checks++; if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_req0 req=%b addr=%h exp 1 fffffff8", bus2.imem_req_o, bus2.imem_addr_o); end
        tick; bus2.imem_rvalid_i = 1'b1; bus2.imem_rdata_i = 32'h1111_1111; #2;
        checks++; if (bus2.imem_req_o !== 1'b0) begin errors++; $display("FAIL wrap_wait0 act=%b exp=0", bus2.imem_req_o); end
        tick; bus2.imem_rvalid_i = 1'b0; #2;
        checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFF8 || pc42 !== 32'hFFFF_FFFC || instr2 !== 32'h1111_1111) begin errors++; $display("FAIL wrap_out0 valid=%b pc=%h pc4=%h instr=%h exp 1 fffffff8 fffffffc 11111111", valid2, pc2, pc42, instr2); end
        checks++; if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req1 req=%b addr=%h exp 1 fffffffc", bus2.imem_req_o, bus2.imem_addr_o); end
        tick; bus2.imem_rvalid_i = 1'b1; bus2.imem_rdata_i = 32'h2222_2222; #2;
        checks++; if (bus2.imem_req_o !== 1'b0) begin errors++; $display("FAIL wrap_wait1 act=%b exp=0", bus2.imem_req_o); end
        tick; bus2.imem_rvalid_i = 1'b0; #2;
        checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || pc42 !== 32'h0 || instr2 !== 32'h2222_2222) begin errors++; $display("FAIL wrap_out1 valid=%b pc=%h pc4=%h instr=%h exp 1 fffffffc 0 22222222", valid2, pc2, pc42, instr2); end
        checks++; if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_req2 req=%b addr=%h exp 1 0", bus2.imem_req_o, bus2.imem_addr_o); end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; target = '0;
        rdy_en = 1'b1; rsp_lat = 1; ovr_en = 1'b0; ovr_dat = '0; spur = 1'b0; spur_dat = '0;
        stall2 = 1'b0; redirect2 = 1'b0; target2 = '0;
        bus2.imem_ready_i = 1'b0; bus2.imem_rvalid_i = 1'b0; bus2.imem_rdata_i = '0;
        test_reset;
        test_stream;
        test_stall;
        test_redirect_wait;
        test_redirect_accept;
        test_ready_low;
        test_reset_mid_wait;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
